// File: rtl/inv_array_sched.sv
// inv_array_sched: ROWS x COLS array of WIDTH-bit registers.
// Two requesters write single bits into it through a round-robin arbiter.
// A scan engine streams the bitwise inverse of every entry in row-major
// order over a valid/ready handshake.
module inv_array_sched #(
  parameter int WIDTH = 8,
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  localparam int RW   = (ROWS  > 1) ? $clog2(ROWS)  : 1,
  localparam int CW   = (COLS  > 1) ? $clog2(COLS)  : 1,
  localparam int BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [RW-1:0]    a_row,
  input  logic [CW-1:0]    a_col,
  input  logic [BW-1:0]    a_bit,
  input  logic             a_val,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [RW-1:0]    b_row,
  input  logic [CW-1:0]    b_col,
  input  logic [BW-1:0]    b_bit,
  input  logic             b_val,
  input  logic             start,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_arr [ROWS][COLS];
  logic             r_ptr;              // 0: A has priority, 1: B has priority
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_done;
  logic             r_busy;

  logic             w_wr_open;
  logic             w_a_grant;
  logic             w_b_grant;
  logic             w_wr_en;
  logic [RW-1:0]    w_wr_row;
  logic [CW-1:0]    w_wr_col;
  logic [BW-1:0]    w_wr_bit;
  logic             w_wr_val;
  logic             w_col_wrap;
  logic             w_last;
  logic [RW-1:0]    w_next_row;
  logic [CW-1:0]    w_next_col;
  logic             w_hs;

  // Writes are only open in IDLE and never in the cycle a scan is requested,
  // so the array cannot change underneath a scan.
  assign w_wr_open = (r_state == S_IDLE) && !start;
  assign w_a_grant = w_wr_open && a_valid && (!b_valid || !r_ptr);
  assign w_b_grant = w_wr_open && b_valid && (!a_valid ||  r_ptr);
  assign a_ready   = w_a_grant;
  assign b_ready   = w_b_grant;

  assign w_wr_en  = w_a_grant || w_b_grant;
  assign w_wr_row = w_a_grant ? a_row : b_row;
  assign w_wr_col = w_a_grant ? a_col : b_col;
  assign w_wr_bit = w_a_grant ? a_bit : b_bit;
  assign w_wr_val = w_a_grant ? a_val : b_val;

  // Row-major successor of the current scan position.
  assign w_col_wrap = (r_col == CW'(COLS - 1));
  assign w_last     = w_col_wrap && (r_row == RW'(ROWS - 1));
  assign w_next_col = w_col_wrap ? '0 : r_col + CW'(1);
  assign w_next_row = w_col_wrap ? r_row + RW'(1) : r_row;
  assign w_hs       = r_out_valid && out_ready;

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

  // Array storage: clear on reset, otherwise update the single granted bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_arr[r][c] <= '0;
        end
      end
    end else if (w_wr_en) begin
      r_arr[w_wr_row][w_wr_col][w_wr_bit] <= w_wr_val;
    end
  end

  // Round-robin pointer: hand priority to the other requester after any grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (w_a_grant) begin
      r_ptr <= 1'b1;
    end else if (w_b_grant) begin
      r_ptr <= 1'b0;
    end
  end

  // Scan FSM with registered outputs; first entry is loaded on the start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_out_data  <= '1;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_SCAN;
            r_row       <= '0;
            r_col       <= '0;
            r_out_data  <= ~r_arr[0][0];
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        S_SCAN: begin
          if (w_hs) begin
            if (w_last) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_row      <= w_next_row;
              r_col      <= w_next_col;
              r_out_data <= ~r_arr[w_next_row][w_next_col];
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_done      <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_array_sched.sv
// Directed bench for inv_array_sched: bit writes, arbitration, scan,
// backpressure, start/write collision and reset during a scan.
module tb_inv_array_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_valid, a_ready, a_val;
  logic       b_valid, b_ready, b_val;
  logic [0:0] a_row, a_col, b_row, b_col;
  logic [2:0] a_bit, b_bit;
  logic       start;
  logic [7:0] out_data;
  logic       out_valid, out_ready, busy, done;

  int total = 0;
  int bad   = 0;

  inv_array_sched #(.WIDTH(8), .ROWS(2), .COLS(2)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_row(a_row), .a_col(a_col),
    .a_bit(a_bit), .a_val(a_val),
    .b_valid(b_valid), .b_ready(b_ready), .b_row(b_row), .b_col(b_col),
    .b_bit(b_bit), .b_val(b_val),
    .start(start), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write an 8-bit value bit-by-bit through a single requester.
  task automatic write_byte(input logic use_b, input logic r, input logic c, input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (use_b) begin
        b_valid = 1'b1; b_row = r; b_col = c; b_bit = 3'(i); b_val = v[i];
      end else begin
        a_valid = 1'b1; a_row = r; a_col = c; a_bit = 3'(i); a_val = v[i];
      end
      #1;
      chk(use_b ? "wr_b_ready" : "wr_a_ready", use_b ? b_ready : a_ready, 1);
      $display("write %s (%0d,%0d) bit%0d=%0d", use_b ? "B" : "A", r, c, i, v[i]);
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  // Start a scan with out_ready held high and check four entries plus done.
  task automatic do_scan(input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp_q [4];
    exp_q[0] = e0; exp_q[1] = e1; exp_q[2] = e2; exp_q[3] = e3;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("scan_valid", out_valid, 1);
      chk("scan_data", out_data, exp_q[i]);
      $display("scan entry %0d data=%h", i, out_data);
      tick();
    end
    chk("scan_done_hi", done, 1);
    chk("scan_valid_lo", out_valid, 0);
    tick();
    chk("scan_done_lo", done, 0);
    chk("scan_busy_lo", busy, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    a_valid = 1'b0; a_row = '0; a_col = '0; a_bit = '0; a_val = 1'b0;
    b_valid = 1'b0; b_row = '0; b_col = '0; b_bit = '0; b_val = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset values
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 8'hFF);

    // Arbitration: both valid -> A, B, A, B
    a_valid = 1'b1; a_row = 1'b0; a_col = 1'b1; a_bit = 3'd7; a_val = 1'b1;
    b_valid = 1'b1; b_row = 1'b1; b_col = 1'b0; b_bit = 3'd0; b_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb_a_ready", a_ready, (i % 2 == 0) ? 1 : 0);
      chk("arb_b_ready", b_ready, (i % 2 == 1) ? 1 : 0);
      $display("arb cycle %0d a_ready=%0d b_ready=%0d", i, a_ready, b_ready);
      tick();
    end
    // Lone B request is granted immediately
    a_valid = 1'b0;
    b_row = 1'b1; b_col = 1'b1; b_bit = 3'd3; b_val = 1'b1;
    #1;
    chk("solo_b_ready", b_ready, 1);
    chk("solo_b_a_ready", a_ready, 0);
    tick();
    // Pointer now back on A
    a_valid = 1'b1;
    #1;
    chk("post_solo_a_ready", a_ready, 1);
    chk("post_solo_b_ready", b_ready, 0);
    tick();
    a_valid = 1'b0; b_valid = 1'b0;
    // (0,1)=80, (1,0)=01, (1,1)=08
    do_scan(8'hFF, 8'h7F, 8'hFE, 8'hF7);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Bit-load and scan
    write_byte(1'b0, 1'b0, 1'b0, 8'hAD);
    write_byte(1'b1, 1'b1, 1'b1, 8'h42);
    do_scan(8'h52, 8'hFF, 8'hFF, 8'hBD);

    // Backpressure: out_ready low for 3 cycles after start
    start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 8'h52);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_release_data", out_data, 8'h52);
    tick();
    chk("bp_next_data", out_data, 8'hFF);
    tick();
    chk("bp_third_data", out_data, 8'hFF);
    tick();
    chk("bp_last_data", out_data, 8'hBD);
    tick();
    chk("bp_done", done, 1);
    tick();
    chk("bp_idle_busy", busy, 0);

    // Start/write collision: write to (0,1) bit0 must be dropped
    start = 1'b1; out_ready = 1'b0;
    a_valid = 1'b1; a_row = 1'b0; a_col = 1'b1; a_bit = 3'd0; a_val = 1'b1;
    #1;
    chk("coll_a_ready", a_ready, 0);
    tick();
    start = 1'b0;
    chk("coll_busy", busy, 1);
    chk("coll_valid", out_valid, 1);
    #1;
    chk("coll_scan_a_ready", a_ready, 0);
    a_valid = 1'b0;
    out_ready = 1'b1;
    chk("coll_data0", out_data, 8'h52);
    tick();
    chk("coll_data1", out_data, 8'hFF);
    tick();
    chk("coll_data2", out_data, 8'hFF);
    tick();
    chk("coll_data3", out_data, 8'hBD);
    tick();
    chk("coll_done", done, 1);
    tick();

    // Reset mid-scan after the 2nd handshake
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("mid_data0", out_data, 8'h52);
    tick();
    chk("mid_data1", out_data, 8'hFF);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", out_data, 8'hFF);
    tick();
    chk("mid_rst_done2", done, 0);
    do_scan(8'hFF, 8'hFF, 8'hFF, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inv_array_sched.md
INV_ARRAY_SCHED -- requirements
Module: inv_array_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning entry width in bits.
REQ-002 SHALL have parameter ROWS, default 2, meaning array rows.
REQ-003 SHALL have parameter COLS, default 2, meaning array columns.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have ports a_valid/b_valid  input  1  bit-write request from requester A / B.
REQ-007 SHALL have ports a_ready/b_ready  output  1  grant; a write is accepted on the cycle where valid and ready are both high.
REQ-008 SHALL have ports a_row/b_row  input  $clog2(ROWS)  target row.
REQ-009 SHALL have ports a_col/b_col  input  $clog2(COLS)  target column.
REQ-010 SHALL have ports a_bit/b_bit  input  $clog2(WIDTH)  target bit index.
REQ-011 SHALL have ports a_val/b_val  input  1  bit value to store.
REQ-012 SHALL have port start  input  1  scan request pulse.
REQ-013 SHALL have port out_data  output  WIDTH  bitwise inverse of the scanned entry.
REQ-014 SHALL have ports out_valid  output  1 and out_ready  input  1, forming the output handshake.
REQ-015 SHALL have ports busy  output  1  high while not IDLE, and done  output  1  one-cycle scan-complete pulse.

Function
REQ-016 SHALL hold a ROWS x COLS array of WIDTH-bit registers; an accepted write updates only arr[row][col][bit] at the next edge.
REQ-017 SHALL accept at most one write per cycle; when both requesters are valid, SHALL grant round-robin, with the pointer toggling after each accepted write.
REQ-018 SHALL grant a sole valid requester immediately, regardless of the pointer, and then set the pointer to the other requester.
REQ-019 SHALL drive a_ready/b_ready combinationally; both SHALL be low when the state is not IDLE or when start is high.
REQ-020 SHALL implement FSM states IDLE, SCAN and DONE.
  - IDLE -> SCAN on start.
  - SCAN -> DONE on the handshake of the last entry.
  - DONE -> IDLE unconditionally after one cycle.
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL, in SCAN, present entries in row-major order (0,0),(0,1),...,(ROWS-1,COLS-1) with out_data = ~arr[r][c] and out_valid=1.
  - First entry appears on the cycle after start is accepted (latency 1).
REQ-023 SHALL hold out_data stable while out_valid=1 and out_ready=0, and SHALL advance the scan index only on out_valid&out_ready.
REQ-024 SHALL allow back-to-back handshakes, giving one entry per cycle when out_ready is held high.
REQ-025 SHALL read array contents registered at scan time; writes cannot occur during SCAN/DONE (REQ-019), so the scan is a consistent snapshot.
REQ-026 SHALL assert done=1 only in DONE, and out_valid=0 in IDLE and DONE.
REQ-027 SHALL wrap the scan index to 0 on entering SCAN.

Reset
REQ-028 SHALL, on rst high at a clock edge, take the following reset values:
  - all array entries = 0;
  - state = IDLE;
  - scan index = 0;
  - round-robin pointer = A;
  - out_valid=0, done=0, busy=0, out_data=~0 (all ones, the inverse of entry 0).
REQ-029 SHALL give rst priority over start and writes in the same cycle, and SHALL abort an in-progress scan without asserting done.

Verification
REQ-030 Bit-load and scan:
  - Stimulus: via A, write 0xAD into (0,0) bit-by-bit (bits 0..7); via B, write 0x42 into (1,1); start; hold out_ready=1.
  - Required response: out_data sequence 0x52, 0xFF, 0xFF, 0xBD on 4 consecutive cycles; then done=1 for exactly one cycle.
REQ-031 Arbitration:
  - Stimulus: after reset, a_valid=b_valid=1 for 4 cycles.
  - Required response: grants A, B, A, B; a single B request then gets an immediate grant.
REQ-032 Backpressure:
  - Stimulus: out_ready=0 for 3 cycles after start.
  - Required response: out_data=0x52 and out_valid=1 held stable for those cycles; the scan index does not advance.
REQ-033 Start/write collision:
  - Stimulus: start and a_valid asserted together in IDLE.
  - Required response: a_ready=0, the array is unchanged, and SCAN is entered.
REQ-034 Reset mid-scan:
  - Stimulus: rst asserted after the 2nd handshake.
  - Required response: next cycle IDLE, out_valid=0, done never asserted, array all zero; a new scan outputs 0xFF x4.
